// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller: serves LSB loads/stores (priority) and
// instruction fetches over an 8-bit bus with one-cycle read latency.
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_MASK    = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_signal,
    input  logic                  lsb_signal,
    input  logic                  lsb_wr,
    input  logic                  lsb_signed,
    input  logic [1:0]            lsb_len,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_din,
    output logic [31:0]           lsb_dout,
    output logic                  lsb_done,
    input  logic                  if_signal,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_dout,
    output logic                  if_done,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            n_q, n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  lsb_sel_q, lsb_sel_d;
    logic                  signed_q, signed_d;
    logic [31:0]           din_q, din_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic                  ram_wr_q, ram_wr_d;
    logic [31:0]           lsb_dout_q, lsb_dout_d;
    logic [31:0]           if_dout_q, if_dout_d;
    logic                  lsb_done_q, lsb_done_d;
    logic                  if_done_q, if_done_d;

    logic [ADDR_WIDTH-1:0] byte_addr;
    logic [7:0]            st_byte;
    logic [1:0]            rx_idx;
    logic [31:0]           word_full;
    logic [31:0]           load_ext;
    logic                  accept_stall;
    logic                  store_stall;

    assign byte_addr    = addr_q + ADDR_WIDTH'(cnt_q);
    assign rx_idx       = cnt_q[1:0] - 2'd1;
    assign accept_stall = io_buffer_full && (lsb_addr[17:16] == IO_MASK);
    assign store_stall  = io_buffer_full && (byte_addr[17:16] == IO_MASK);

    always_comb begin
        st_byte = din_q[7:0];
        case (cnt_q[1:0])
            2'd0: st_byte = din_q[7:0];
            2'd1: st_byte = din_q[15:8];
            2'd2: st_byte = din_q[23:16];
            2'd3: st_byte = din_q[31:24];
            default: st_byte = din_q[7:0];
        endcase
    end

    // In LOAD, cnt_q counts edges since accept, so ram_din holds byte cnt_q-1.
    always_comb begin
        word_full = data_q;
        case (rx_idx)
            2'd0: word_full[7:0]   = ram_din;
            2'd1: word_full[15:8]  = ram_din;
            2'd2: word_full[23:16] = ram_din;
            2'd3: word_full[31:24] = ram_din;
            default: word_full = data_q;
        endcase
    end

    always_comb begin
        load_ext = word_full;
        if (n_q == 3'd1) begin
            load_ext = {{24{signed_q & word_full[7]}}, word_full[7:0]};
        end else if (n_q == 3'd2) begin
            load_ext = {{16{signed_q & word_full[15]}}, word_full[15:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        addr_d     = addr_q;
        lsb_sel_d  = lsb_sel_q;
        signed_d   = signed_q;
        din_d      = din_q;
        data_d     = data_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = ram_wr_q;
        lsb_dout_d = lsb_dout_q;
        if_dout_d  = if_dout_q;
        lsb_done_d = 1'b0;
        if_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                ram_wr_d = 1'b0;
                if (!clear_signal && (lsb_signal || if_signal)) begin
                    lsb_sel_d = lsb_signal;
                    addr_d    = lsb_signal ? lsb_addr : if_addr;
                    ram_a_d   = lsb_signal ? lsb_addr : if_addr;
                    n_d       = !lsb_signal ? 3'd4 :
                                lsb_len[1]  ? 3'd4 :
                                lsb_len[0]  ? 3'd2 : 3'd1;
                    signed_d  = lsb_signal && lsb_signed;
                    din_d     = lsb_din;
                    data_d    = '0;
                    cnt_d     = '0;
                    if (lsb_signal && lsb_wr) begin
                        state_d = STORE;
                        if (!accept_stall) begin
                            ram_dout_d = lsb_din[7:0];
                            ram_wr_d   = 1'b1;
                            cnt_d      = 3'd1;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                ram_wr_d = 1'b0;
                if (clear_signal || (lsb_sel_q ? !lsb_signal : !if_signal)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        data_d = word_full;
                    end
                    if (cnt_q == n_q) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        if (lsb_sel_q) begin
                            lsb_dout_d = load_ext;
                            lsb_done_d = 1'b1;
                        end else begin
                            if_dout_d = load_ext;
                            if_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q + 3'd1 < n_q) begin
                            ram_a_d = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
                        end
                    end
                end
            end
            STORE: begin
                // cnt_q counts bytes already driven; clear is deliberately ignored here.
                if (cnt_q == n_q) begin
                    ram_wr_d   = 1'b0;
                    lsb_done_d = 1'b1;
                    state_d    = DONE;
                    cnt_d      = '0;
                end else begin
                    ram_a_d = byte_addr;
                    if (store_stall) begin
                        ram_wr_d = 1'b0;
                    end else begin
                        ram_dout_d = st_byte;
                        ram_wr_d   = 1'b1;
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                ram_wr_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            addr_q     <= '0;
            lsb_sel_q  <= 1'b0;
            signed_q   <= 1'b0;
            din_q      <= '0;
            data_q     <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            lsb_dout_q <= '0;
            if_dout_q  <= '0;
            lsb_done_q <= 1'b0;
            if_done_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            lsb_sel_q  <= lsb_sel_d;
            signed_q   <= signed_d;
            din_q      <= din_d;
            data_q     <= data_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            lsb_dout_q <= lsb_dout_d;
            if_dout_q  <= if_dout_d;
            lsb_done_q <= lsb_done_d;
            if_done_q  <= if_done_d;
        end
    end

    assign ram_a    = ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q;
    assign lsb_dout = lsb_dout_q;
    assign if_dout  = if_dout_q;
    assign lsb_done = lsb_done_q;
    assign if_done  = if_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-latency RAM model, write log, and
// hand-computed expectations for loads, stores, stalls, clears and reset.
module tb_mem_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_signal;
    logic        lsb_signal;
    logic        lsb_wr;
    logic        lsb_signed;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_din;
    logic [31:0] lsb_dout;
    logic        lsb_done;
    logic        if_signal;
    logic [31:0] if_addr;
    logic [31:0] if_dout;
    logic        if_done;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;

    mem_ctrl #(.ADDR_WIDTH(32), .IO_MASK(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .clear_signal(clear_signal),
        .lsb_signal(lsb_signal), .lsb_wr(lsb_wr), .lsb_signed(lsb_signed),
        .lsb_len(lsb_len), .lsb_addr(lsb_addr), .lsb_din(lsb_din),
        .lsb_dout(lsb_dout), .lsb_done(lsb_done),
        .if_signal(if_signal), .if_addr(if_addr), .if_dout(if_dout), .if_done(if_done),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Preloaded contents; anything written by the DUT overrides these.
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h11;
            32'h0000_1001: return 8'h22;
            32'h0000_1002: return 8'h33;
            32'h0000_1003: return 8'h44;
            32'h0000_0500: return 8'h80;
            32'h0000_0600: return 8'hFF;
            32'h0000_0601: return 8'h80;
            32'h0000_3000: return 8'h13;
            32'h0000_3001: return 8'h05;
            32'h0000_3004: return 8'h93;
            32'h0000_3006: return 8'h10;
            32'hFFFF_FFFE: return 8'hA1;
            32'hFFFF_FFFF: return 8'hB2;
            32'h0000_0000: return 8'hC3;
            32'h0000_0001: return 8'hD4;
            default:       return 8'h00;
        endcase
    endfunction

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] wq_a [$];
    logic [7:0]  wq_d [$];
    int          wq_c [$];
    int          cyc = 0;

    always @(posedge clk_in) begin
        cyc++;
        if (ram_wr) begin
            mem[ram_a] = ram_dout;
            wq_a.push_back(ram_a);
            wq_d.push_back(ram_dout);
            wq_c.push_back(cyc);
        end else begin
            ram_din <= mem.exists(ram_a) ? mem[ram_a] : init_byte(ram_a);
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one LSB request; lat = cycles from accept edge to done (-1 on timeout).
    task automatic lsb_req(input string tag, input logic wr, input logic sgn,
                           input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] din, output int lat, output logic [31:0] dout);
        int k;
        @(negedge clk_in);
        lsb_signal = 1'b1; lsb_wr = wr; lsb_signed = sgn;
        lsb_len = len; lsb_addr = addr; lsb_din = din;
        k = 0; lat = -1;
        while (k < 40 && lat < 0) begin
            @(posedge clk_in); #1; k++;
            if (lsb_done) lat = k - 1;
        end
        dout = lsb_dout;
        lsb_signal = 1'b0;
        @(posedge clk_in); #1;
        check_val({tag, "_pulse"}, 32'(lsb_done), 32'd0);
    endtask

    int          lat, k, j, wb, saw_wr, ovl;
    logic [31:0] dout;
    logic [7:0]  exp_b [4];

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0;
        lsb_signal = 1'b0; lsb_wr = 1'b0; lsb_signed = 1'b0; lsb_len = 2'b00;
        lsb_addr = '0; lsb_din = '0; if_signal = 1'b0; if_addr = '0;
        io_buffer_full = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_val("rst_ram_a", ram_a, 32'h0);
        check_val("rst_wr_dout", {23'd0, ram_wr, ram_dout}, 32'h0);
        check_val("rst_dones", {30'd0, lsb_done, if_done}, 32'h0);
        check_val("rst_lsb_dout", lsb_dout, 32'h0);
        check_val("rst_if_dout", if_dout, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;

        lsb_req("word_ld", 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, lat, dout);
        check_val("word_ld_data", dout, 32'h4433_2211);
        check_val("word_ld_lat", 32'(lat), 32'd5);

        lsb_req("sb_ld", 1'b0, 1'b1, 2'b00, 32'h0500, 32'h0, lat, dout);
        check_val("sb_ld_data", dout, 32'hFFFF_FF80);
        check_val("sb_ld_lat", 32'(lat), 32'd2);

        lsb_req("uh_ld", 1'b0, 1'b0, 2'b01, 32'h0600, 32'h0, lat, dout);
        check_val("uh_ld_data", dout, 32'h0000_80FF);
        check_val("uh_ld_lat", 32'(lat), 32'd3);

        lsb_req("sh_ld", 1'b0, 1'b1, 2'b01, 32'h0600, 32'h0, lat, dout);
        check_val("sh_ld_data", dout, 32'hFFFF_80FF);

        lsb_req("wrap_ld", 1'b0, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, lat, dout);
        check_val("wrap_ld_data", dout, 32'hD4C3_B2A1);

        // Word store: four consecutive byte writes, done after the fourth.
        wb = wq_a.size();
        lsb_req("word_st", 1'b1, 1'b0, 2'b11, 32'h2000, 32'hDEAD_BEEF, lat, dout);
        check_val("word_st_lat", 32'(lat), 32'd4);
        check_val("word_st_nwr", 32'(wq_a.size() - wb), 32'd4);
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++) begin
            if (wb + i < wq_a.size()) begin
                check_val($sformatf("word_st_a%0d", i), wq_a[wb+i], 32'h2000 + 32'(i));
                check_val($sformatf("word_st_d%0d", i), 32'(wq_d[wb+i]), 32'(exp_b[i]));
            end
        end
        if (wb + 3 < wq_c.size())
            check_val("word_st_back2back", 32'(wq_c[wb+3] - wq_c[wb]), 32'd3);

        // IO byte store, first unstalled, then with the buffer full for 3 edges.
        wb = wq_a.size();
        lsb_req("io_st", 1'b1, 1'b0, 2'b00, 32'h0003_0000, 32'h0000_0041, lat, dout);
        check_val("io_st_lat", 32'(lat), 32'd1);
        fork
            begin
                io_buffer_full = 1'b1;
                repeat (3) @(posedge clk_in);
                #1 io_buffer_full = 1'b0;
            end
        join_none
        lsb_req("io_stall", 1'b1, 1'b0, 2'b00, 32'h0003_0000, 32'h0000_0042, lat, dout);
        check_val("io_stall_lat", 32'(lat), 32'd4);
        check_val("io_stall_nwr", 32'(wq_a.size() - wb), 32'd2);
        check_val("io_stall_byte", 32'(mem[32'h0003_0000]), 32'h42);

        // Clear pulse during a word store must not disturb it.
        wb = wq_a.size();
        fork
            begin
                repeat (2) @(posedge clk_in);
                #1 clear_signal = 1'b1;
                @(posedge clk_in);
                #1 clear_signal = 1'b0;
            end
        join_none
        lsb_req("clr_st", 1'b1, 1'b0, 2'b10, 32'h2100, 32'hCAFE_F00D, lat, dout);
        check_val("clr_st_lat", 32'(lat), 32'd4);
        check_val("clr_st_nwr", 32'(wq_a.size() - wb), 32'd4);
        check_val("clr_st_mem", {mem[32'h2103], mem[32'h2102], mem[32'h2101], mem[32'h2100]},
                  32'hCAFE_F00D);

        // Simultaneous requests: LSB first, fetch accepted 2 edges after lsb_done.
        @(negedge clk_in);
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_signed = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h0500;
        if_signal = 1'b1; if_addr = 32'h3000;
        k = 0; lat = -1;
        while (k < 40 && lat < 0) begin
            @(posedge clk_in); #1; k++;
            if (lsb_done || if_done) lat = k - 1;
        end
        check_val("arb_if_first", 32'(if_done), 32'd0);
        check_val("arb_lsb_lat", 32'(lat), 32'd2);
        check_val("arb_lsb_data", lsb_dout, 32'h0000_0080);
        lsb_signal = 1'b0;
        j = 0; ovl = 0; lat = -1;
        while (j < 40 && lat < 0) begin
            @(posedge clk_in); #1; j++;
            if (lsb_done && if_done) ovl++;
            if (if_done) lat = j;
        end
        check_val("arb_if_gap", 32'(lat), 32'd7);
        check_val("arb_overlap", 32'(ovl), 32'd0);
        check_val("arb_if_data", if_dout, 32'h0000_0513);
        if_signal = 1'b0;
        @(posedge clk_in); #1;
        check_val("arb_if_pulse", 32'(if_done), 32'd0);

        // Clear during fetch byte 2 aborts it; the held request is refetched.
        @(negedge clk_in);
        if_signal = 1'b1; if_addr = 32'h3004;
        k = 0; lat = -1; saw_wr = 0;
        while (k < 40 && lat < 0) begin
            @(posedge clk_in); #1; k++;
            if (ram_wr) saw_wr = 1;
            if (if_done) lat = k;
            if (k == 3) clear_signal = 1'b1;
            if (k == 4) clear_signal = 1'b0;
        end
        check_val("clr_if_done_k", 32'(lat), 32'd10);
        check_val("clr_if_wr", 32'(saw_wr), 32'd0);
        check_val("clr_if_data", if_dout, 32'h0010_0093);
        if_signal = 1'b0;
        @(posedge clk_in); #1;

        // rdy low holds a pending done pulse.
        @(negedge clk_in);
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_signed = 1'b1; lsb_len = 2'b01; lsb_addr = 32'h0600;
        k = 0; lat = -1;
        while (k < 40 && lat < 0) begin
            @(posedge clk_in); #1; k++;
            if (lsb_done) lat = k - 1;
        end
        check_val("rdy_lat", 32'(lat), 32'd3);
        rdy_in = 1'b0; lsb_signal = 1'b0;
        k = 0;
        repeat (3) begin
            @(posedge clk_in); #1;
            if (lsb_done) k++;
        end
        check_val("rdy_hold", 32'(k), 32'd3);
        rdy_in = 1'b1;
        @(posedge clk_in); #1;
        check_val("rdy_release", 32'(lsb_done), 32'd0);

        // Reset mid-store: immediate zeros, no resumption, normal service afterwards.
        wb = wq_a.size();
        @(negedge clk_in);
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b10; lsb_addr = 32'h4000; lsb_din = 32'h0102_0304;
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        check_val("rstmid_ram_a", ram_a, 32'h0);
        check_val("rstmid_wr_dout", {23'd0, ram_wr, ram_dout}, 32'h0);
        check_val("rstmid_done", 32'(lsb_done), 32'd0);
        lsb_signal = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        check_val("rstmid_nwr", 32'(wq_a.size() - wb), 32'd1);
        lsb_req("post_rst", 1'b0, 1'b0, 2'b00, 32'h4000, 32'h0, lat, dout);
        check_val("post_rst_data", dout, 32'h0000_0004);
        check_val("post_rst_lat", 32'(lat), 32'd2);

        #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
